// File: rtl/calc_pkg.sv
// Shared types for the keypad calculator sequencer: FSM state encoding and ALU op codes.
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSUB = 2'b10,
    OP_PASS = 2'b11
  } op_e;

endpackage

// File: rtl/calc_if.sv
// Keypad-side controls and display-side results of the calculator sequencer, bundled as one port.
interface calc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             enter;
  logic             abort;
  logic             chain;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] operand_in;
  logic             clr_input;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             disp_sel;
  logic [WIDTH-1:0] disp_value;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  modport slave (
    input  enter, abort, chain, op_sel, operand_in,
    output clr_input, a_reg, b_reg, result, ovf, disp_sel, disp_value, op_count, busy
  );

  modport master (
    output enter, abort, chain, op_sel, operand_in,
    input  clr_input, a_reg, b_reg, result, ovf, disp_sel, disp_value, op_count, busy
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational signed ALU: one guard bit detects overflow, optional clamp to the signed limits.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH:0] ax;
  logic [WIDTH:0] bx;
  logic [WIDTH:0] sum;

  always_comb begin
    ax = {a[WIDTH-1], a};
    bx = {b[WIDTH-1], b};
    sum = ax;
    case (op)
      OP_ADD:  sum = ax + bx;
      OP_SUB:  sum = ax - bx;
      OP_RSUB: sum = bx - ax;
      OP_PASS: sum = ax;
      default: sum = ax;
    endcase
    // guard bit disagreeing with the MSB means the true result left the WIDTH-bit range
    ovf = sum[WIDTH] ^ sum[WIDTH-1];
    y   = sum[WIDTH-1:0];
    if (SATURATE && ovf) begin
      y = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: captures A and B on ENTER, runs one registered ALU op,
// shows the result and optionally chains it into the next operation.
//
// state  | meaning
// S_IDLE | input unit held clear, waiting for first ENTER
// S_A    | operand A being keyed in
// S_B    | operand B being keyed in (A latched or chained from result)
// S_EXEC | one-cycle ALU execute, result/ovf/op_count registered on exit
// S_RES  | result on display; ENTER starts next op (chain selects A source)
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic CLK,
  input  logic CLR,
  calc_if.slave bus
);

  state_e           state_q,     state_d;
  op_e              op_q,        op_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             ovf_q,       ovf_d;
  logic             clr_input_q, clr_input_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ovf;

  calc_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    clr_input_d = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enter) state_d = S_A;
        end
        S_A: begin
          if (bus.enter) begin
            a_d         = bus.operand_in;
            clr_input_d = 1'b1;
            state_d     = S_B;
          end
        end
        S_B: begin
          if (bus.enter) begin
            b_d         = bus.operand_in;
            op_d        = op_e'(bus.op_sel);
            clr_input_d = 1'b1;
            state_d     = S_EXEC;
          end
        end
        S_EXEC: begin
          // ENTER is deliberately ignored here; execute always takes exactly one cycle
          result_d = alu_y;
          ovf_d    = alu_ovf;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = S_RES;
        end
        S_RES: begin
          if (bus.enter) begin
            clr_input_d = 1'b1;
            b_d         = '0;
            if (bus.chain) begin
              a_d     = result_q;
              state_d = S_B;
            end else begin
              a_d     = '0;
              state_d = S_A;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // input unit is held clear for as long as the sequencer sits idle
    if (state_d == S_IDLE) clr_input_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      clr_input_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      clr_input_q <= clr_input_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.clr_input  = clr_input_q;
  assign bus.a_reg      = a_q;
  assign bus.b_reg      = b_q;
  assign bus.result     = result_q;
  assign bus.ovf        = ovf_q;
  assign bus.op_count   = cnt_q;
  assign bus.busy       = (state_q == S_EXEC);
  assign bus.disp_sel   = (state_q == S_RES);
  assign bus.disp_value = bus.disp_sel ? result_q : bus.operand_in;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: three variants (wrap, saturate, 2-bit counter) driven in lockstep,
// expected results queued at the B capture and checked when the result is displayed.
module tb_calc_sequencer;

  typedef struct {
    logic [7:0] y0;
    logic       o0;
    logic [7:0] y1;
    logic       o1;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       clr_n;
  logic       enter, abort, chain;
  logic [1:0] op_sel;
  logic [7:0] operand;

  int   n_cmp;
  int   n_err;
  int   model_cnt;
  logic [7:0] last_y0, last_y1;
  logic       last_o0, last_o1;
  exp_t sb_q[$];

  calc_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
  calc_if #(.WIDTH(8), .CNT_W(8)) bus1 ();
  calc_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  assign bus0.enter = enter;  assign bus0.abort = abort;  assign bus0.chain = chain;
  assign bus0.op_sel = op_sel; assign bus0.operand_in = operand;
  assign bus1.enter = enter;  assign bus1.abort = abort;  assign bus1.chain = chain;
  assign bus1.op_sel = op_sel; assign bus1.operand_in = operand;
  assign bus2.enter = enter;  assign bus2.abort = abort;  assign bus2.chain = chain;
  assign bus2.op_sel = op_sel; assign bus2.operand_in = operand;

  calc_sequencer #(.WIDTH(8), .CNT_W(8), .SATURATE(1'b0)) dut0 (.CLK(clk), .CLR(clr_n), .bus(bus0));
  calc_sequencer #(.WIDTH(8), .CNT_W(8), .SATURATE(1'b1)) dut1 (.CLK(clk), .CLR(clr_n), .bus(bus1));
  calc_sequencer #(.WIDTH(8), .CNT_W(2), .SATURATE(1'b0)) dut2 (.CLK(clk), .CLR(clr_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op, input bit sat);
    int sa, sb, r;
    logic o;
    logic [7:0] y;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = sb - sa;
      default: r = sa;
    endcase
    o = (r > 127) || (r < -128);
    y = r[7:0];
    if (sat && r > 127) y = 8'h7F;
    else if (sat && r < -128) y = 8'h80;
    return {o, y};
  endfunction

  task automatic press(input logic [7:0] v, input logic [1:0] op, input bit ch);
    @(negedge clk);
    operand = v;
    op_sel  = op;
    chain   = ch;
    enter   = 1'b1;
    @(negedge clk);
    enter   = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    exp_t e;
    logic [8:0] r0, r1;
    r0 = alu_ref(a, b, op, 1'b0);
    r1 = alu_ref(a, b, op, 1'b1);
    model_cnt++;
    e.y0 = r0[7:0]; e.o0 = r0[8];
    e.y1 = r1[7:0]; e.o1 = r1[8];
    e.cnt = model_cnt[7:0];
    sb_q.push_back(e);
  endtask

  task automatic wait_result(input int exp_lat);
    exp_t e;
    int n = 0;
    while (bus0.disp_sel !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("result_wrap", bus0.result, e.y0);
      chk("ovf_wrap",    bus0.ovf,    e.o0);
      chk("result_sat",  bus1.result, e.y1);
      chk("ovf_sat",     bus1.ovf,    e.o1);
      chk("op_count",    bus0.op_count, e.cnt);
      chk("op_count_w2", bus2.op_count, e.cnt[1:0]);
      chk("disp_value",  bus0.disp_value, e.y0);
      chk("busy_res",    bus0.busy, 1'b0);
      last_y0 = e.y0; last_o0 = e.o0;
      last_y1 = e.y1; last_o1 = e.o1;
    end
  endtask

  // assumes the sequencer is in S_A, or in S_B with a chained A when chained=1
  task automatic do_calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input bit chained);
    if (!chained) begin
      press(a, 2'b00, 1'b0);
      chk("a_latch", bus0.a_reg, a);
      chk("clr_pulse_a", bus0.clr_input, 1'b1);
    end
    push_exp(a, b, op);
    press(b, op, 1'b0);
    chk("b_latch", bus0.b_reg, b);
    chk("busy_exec", bus0.busy, 1'b1);
    chk("clr_pulse_b", bus0.clr_input, 1'b1);
    wait_result(1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; model_cnt = 0;
    last_y0 = '0; last_y1 = '0; last_o0 = 1'b0; last_o1 = 1'b0;
    enter = 1'b0; abort = 1'b0; chain = 1'b0; op_sel = 2'b00; operand = 8'h00;
    clr_n = 1'b1;
    #2 clr_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a",        bus0.a_reg, 8'h00);
    chk("rst_b",        bus0.b_reg, 8'h00);
    chk("rst_result",   bus1.result, 8'h00);
    chk("rst_ovf",      bus0.ovf, 1'b0);
    chk("rst_cnt",      bus0.op_count, 8'h00);
    chk("rst_cnt_w2",   bus2.op_count, 2'b00);
    chk("rst_clr_in",   bus0.clr_input, 1'b1);
    chk("rst_disp_sel", bus0.disp_sel, 1'b0);
    chk("rst_busy",     bus0.busy, 1'b0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("idle_clr_in",  bus0.clr_input, 1'b1);

    press(8'h00, 2'b00, 1'b0);
    chk("sa_clr_in",    bus0.clr_input, 1'b0);
    operand = 8'h5A;
    #1 chk("disp_operand", bus0.disp_value, 8'h5A);
    do_calc(8'h05, 8'h03, 2'b00, 1'b0);

    press(8'h00, 2'b00, 1'b1);
    chk("chain_a",      bus0.a_reg, 8'h08);
    chk("chain_b",      bus0.b_reg, 8'h00);
    do_calc(8'h08, 8'h02, 2'b01, 1'b1);
    chk("chain_a_kept", bus0.a_reg, 8'h08);

    press(8'h00, 2'b00, 1'b0);
    chk("unchain_a",    bus0.a_reg, 8'h00);
    do_calc(8'h7F, 8'h01, 2'b00, 1'b0);
    press(8'h00, 2'b00, 1'b0);
    do_calc(8'h80, 8'h01, 2'b01, 1'b0);

    // ENTER held through the execute cycle must not advance or double count
    press(8'h00, 2'b00, 1'b0);
    press(8'h03, 2'b00, 1'b0);
    push_exp(8'h03, 8'h0A, 2'b10);
    @(negedge clk);
    operand = 8'h0A; op_sel = 2'b10; chain = 1'b0; enter = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enter = 1'b0;
    wait_result(0);
    @(negedge clk);
    chk("exec_enter_state", bus0.disp_sel, 1'b1);
    chk("exec_enter_cnt",   bus0.op_count, model_cnt[7:0]);

    press(8'h00, 2'b00, 1'b0);
    do_calc(8'h85, 8'h00, 2'b11, 1'b0);

    // abort wins over a simultaneous ENTER in S_B
    press(8'h00, 2'b00, 1'b0);
    press(8'h11, 2'b00, 1'b0);
    @(negedge clk);
    abort = 1'b1; enter = 1'b1; operand = 8'h22;
    @(negedge clk);
    abort = 1'b0; enter = 1'b0;
    chk("abort_a",      bus0.a_reg, 8'h00);
    chk("abort_b",      bus0.b_reg, 8'h00);
    chk("abort_disp",   bus0.disp_sel, 1'b0);
    chk("abort_result", bus0.result, last_y0);
    chk("abort_ovf",    bus1.ovf, last_o1);
    chk("abort_cnt",    bus0.op_count, model_cnt[7:0]);
    chk("abort_clr_in", bus0.clr_input, 1'b1);

    // abort during execute drops the op
    press(8'h00, 2'b00, 1'b0);
    press(8'h01, 2'b00, 1'b0);
    press(8'h01, 2'b00, 1'b0);
    chk("abx_busy",     bus0.busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abx_cnt",      bus0.op_count, model_cnt[7:0]);
    chk("abx_cnt_w2",   bus2.op_count, model_cnt[1:0]);
    chk("abx_result",   bus0.result, last_y0);
    chk("abx_busy_off", bus0.busy, 1'b0);
    chk("abx_disp",     bus0.disp_sel, 1'b0);

    // CLR during execute returns everything to reset values immediately
    press(8'h00, 2'b00, 1'b0);
    press(8'h02, 2'b00, 1'b0);
    press(8'h03, 2'b00, 1'b0);
    chk("clr_busy_pre", bus0.busy, 1'b1);
    clr_n = 1'b0;
    #1;
    chk("clr_cnt",      bus0.op_count, 8'h00);
    chk("clr_result",   bus0.result, 8'h00);
    chk("clr_a",        bus0.a_reg, 8'h00);
    chk("clr_clr_in",   bus0.clr_input, 1'b1);
    chk("clr_busy",     bus0.busy, 1'b0);
    model_cnt = 0;
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 2'($urandom_range(0, 3));
      press(8'h00, 2'b00, 1'b0);
      do_calc(ra, rb, rop, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
